// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
// The frame is start, eight data bits LSB first, odd parity, stop.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_SETUP,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_DONE
  } ps2_tx_state_e;

  localparam int FRAME_BITS = 11;

  // Parity bit that makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small byte queue with a combinational head; DEPTH must be a power of two.
// A push while full is dropped, so callers gate pushes with !full.
module ps2_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes and clocks them out
// on an open-drain clock/data pair, aborting and retrying on host inhibit.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF    = 2000,
  parameter int IDLE_CYCLES = 1000,
  parameter int FIFO_DEPTH  = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_ready,
  output logic [CW-1:0] fifo_count,
  output logic          busy,
  output logic          abort,
  input  logic          ps2_clk_i,
  output logic          ps2_clk_oe,
  input  logic          ps2_data_i,
  output logic          ps2_data_oe
);

  localparam int PW = $clog2(CLK_HALF + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic          clk_meta_reg;
  logic          clk_s;
  logic          data_meta_reg;
  logic          data_s;

  ps2_tx_state_e state_reg;
  logic [PW-1:0] phase_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic [3:0]    bit_idx_reg;
  logic [9:0]    payload_reg;
  logic          clk_oe_reg;
  logic          data_oe_reg;
  logic          abort_reg;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          phase_end;
  logic          inhibit;

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_ready    = !fifo_full;
  assign fifo_pop    = (state_reg == ST_DONE);
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_WAIT_IDLE);
  assign abort       = abort_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign phase_end   = (phase_reg == PW'(CLK_HALF - 1));
  // Only trust clk_s from the third cycle of a released phase, once the
  // synchroniser has caught up with our own release of the line.
  assign inhibit     = !clk_s && (phase_reg >= PW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_reg  <= 1'b0;
      clk_s         <= 1'b0;
      data_meta_reg <= 1'b0;
      data_s        <= 1'b0;
    end else begin
      clk_meta_reg  <= ps2_clk_i;
      clk_s         <= clk_meta_reg;
      data_meta_reg <= ps2_data_i;
      data_s        <= data_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= '0;
      idle_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      payload_reg  <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_reg    <= ST_WAIT_IDLE;
            idle_cnt_reg <= '0;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            if (idle_cnt_reg == IW'(IDLE_CYCLES - 1)) begin
              state_reg   <= ST_SETUP;
              phase_reg   <= '0;
              bit_idx_reg <= '0;
              payload_reg <= {1'b1, odd_parity(fifo_head), fifo_head};
              data_oe_reg <= 1'b1;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + IW'(1);
            end
          end else begin
            idle_cnt_reg <= '0;
          end
        end

        ST_SETUP, ST_CLK_HIGH: begin
          if (inhibit) begin
            // Host inhibit mid-frame: let go of both lines and resend later.
            state_reg    <= ST_WAIT_IDLE;
            idle_cnt_reg <= '0;
            phase_reg    <= '0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            abort_reg    <= 1'b1;
          end else if (phase_end) begin
            state_reg  <= ST_CLK_LOW;
            phase_reg  <= '0;
            clk_oe_reg <= 1'b1;
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end

        ST_CLK_LOW: begin
          if (phase_end) begin
            phase_reg  <= '0;
            clk_oe_reg <= 1'b0;
            if (bit_idx_reg == 4'(FRAME_BITS - 1)) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg   <= ST_CLK_HIGH;
              bit_idx_reg <= bit_idx_reg + 4'd1;
              data_oe_reg <= ~payload_reg[0];
              payload_reg <= payload_reg >> 1;
            end
          end else begin
            phase_reg <= phase_reg + PW'(1);
          end
        end

        ST_DONE: begin
          data_oe_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end

        default: begin
          state_reg   <= ST_IDLE;
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a pull-up model on both lines and a
// host that can hold the clock low; frames are decoded at device falling edges.
module tb_ps2_device_tx;

  localparam int CLK_HALF    = 4;
  localparam int IDLE_CYCLES = 8;
  localparam int FIFO_DEPTH  = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       abort;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       host_clk_low;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  int checks;
  int errors;
  int abort_cnt;
  logic bit_q [$];

  assign ps2_clk_line  = !(ps2_clk_oe || host_clk_low);
  assign ps2_data_line = !ps2_data_oe;

  ps2_device_tx #(
    .CLK_HALF    (CLK_HALF),
    .IDLE_CYCLES (IDLE_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .abort       (abort),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_i  (ps2_data_line),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: samples data on device falling edges, checks pulse width,
  // fall spacing and the idle gap before each start bit.
  initial begin
    logic prev_clk_oe, prev_data_oe, have_rel;
    int frame_pos, low_w, since_fall, gap;
    prev_clk_oe = 0; prev_data_oe = 0; have_rel = 0;
    frame_pos = 0; low_w = 0; since_fall = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_clk_oe = 0; prev_data_oe = 0; have_rel = 0;
        frame_pos = 0; low_w = 0; since_fall = 0; gap = 0;
      end else begin
        since_fall++;
        gap++;
        if (abort) begin
          abort_cnt++;
          frame_pos = 0;
        end
        if (ps2_data_oe && !prev_data_oe && frame_pos == 0 && have_rel)
          check("idle_gap_ge_8", 32'(gap >= IDLE_CYCLES), 1);
        if (ps2_clk_oe && !prev_clk_oe) begin
          bit_q.push_back(ps2_data_line);
          if (frame_pos > 0) check("fall_spacing", since_fall, 2 * CLK_HALF);
          since_fall = 0;
          low_w = 1;
          frame_pos = (frame_pos == 10) ? 0 : frame_pos + 1;
        end else if (ps2_clk_oe) begin
          low_w++;
        end
        if (!ps2_clk_oe && prev_clk_oe) begin
          check("clk_low_width", low_w, CLK_HALF);
          gap = 0;
          have_rel = 1;
        end
        prev_clk_oe = ps2_clk_oe;
        prev_data_oe = ps2_data_oe;
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic exp_ready);
    tx_valid = 1'b1;
    tx_data  = b;
    check($sformatf("tx_ready_push_%02h", b), tx_ready, exp_ready);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    $display("push 0x%02h ready=%0b count=%0d", b, exp_ready, fifo_count);
  endtask

  task automatic get_frame(input string tag, input logic [10:0] exp);
    logic [10:0] f;
    int waited;
    waited = 0;
    while (bit_q.size() < 11 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bit_q.size() < 11) begin
      check({tag, "_timeout"}, bit_q.size(), 11);
      bit_q.delete();
    end else begin
      for (int i = 0; i < 11; i++) f[i] = bit_q.pop_front();
      check(tag, f, exp);
      $display("frame %s: bits=0x%03h byte=0x%02h", tag, f, f[8:1]);
    end
  endtask

  task automatic wait_not_busy(input string tag);
    for (int i = 0; i < 500 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(tag, busy, 0);
  endtask

  // Waits for the device falling edge that starts bit index n.
  task automatic wait_fall(input int n, output logic found);
    logic prev;
    prev = ps2_clk_oe;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); #1;
      if (ps2_clk_oe && !prev && bit_q.size() == n) found = 1;
      prev = ps2_clk_oe;
    end
  endtask

  initial begin
    logic found;
    checks = 0; errors = 0; abort_cnt = 0;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; host_clk_low = 1'b0;

    #3;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", tx_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1: single byte 0x1C (three ones, parity 0)
    push(8'h1C, 1);
    check("t1_count_after_push", fifo_count, 1);
    get_frame("t1_1C", 11'h438);
    check("t1_busy_mid", busy, 1);
    check("t1_count_before_done", fifo_count, 1);
    wait_not_busy("t1_idle");
    check("t1_count_after", fifo_count, 0);
    check("t1_no_abort", abort_cnt, 0);

    // 2: back-to-back bytes
    push(8'hF0, 1);
    push(8'h1C, 1);
    check("t2_count_peak", fifo_count, 2);
    get_frame("t2_F0", 11'h7E0);
    get_frame("t2_1C", 11'h438);
    wait_not_busy("t2_idle");
    check("t2_count_after", fifo_count, 0);

    // 3: host inhibit holds the queue; fifth push refused
    host_clk_low = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    push(8'h44, 1);
    push(8'h55, 0);
    check("t3_count_full", fifo_count, 4);
    check("t3_ready_low", tx_ready, 0);
    repeat (30) @(posedge clk);
    #1;
    check("t3_clk_oe_idle", ps2_clk_oe, 0);
    check("t3_no_bits", bit_q.size(), 0);
    check("t3_busy", busy, 0);
    host_clk_low = 1'b0;
    get_frame("t3_11", 11'h622);
    get_frame("t3_22", 11'h644);
    get_frame("t3_33", 11'h666);
    get_frame("t3_44", 11'h688);
    wait_not_busy("t3_idle");
    check("t3_count_after", fifo_count, 0);

    // 4: inhibit during CLK_HIGH of bit index 5 -> abort and full resend
    push(8'h5A, 1);
    begin : t4
      logic prev;
      found = 0;
      prev = ps2_clk_oe;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(posedge clk); #1;
        if (!ps2_clk_oe && prev && bit_q.size() == 5) found = 1;
        prev = ps2_clk_oe;
      end
    end
    check("t4_reach_bit5", found, 1);
    host_clk_low = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (abort) found = 1;
    end
    check("t4_abort_seen", found, 1);
    check("t4_clk_oe_released", ps2_clk_oe, 0);
    check("t4_data_oe_released", ps2_data_oe, 0);
    check("t4_count_kept", fifo_count, 1);
    @(posedge clk); #1;
    check("t4_abort_one_cycle", abort, 0);
    repeat (95) @(posedge clk);
    #1;
    bit_q.delete();
    host_clk_low = 1'b0;
    get_frame("t4_5A_resend", 11'h6B4);
    wait_not_busy("t4_idle");
    check("t4_abort_count", abort_cnt, 1);
    check("t4_count_after", fifo_count, 0);

    // 5: host pulls clock low once the 11th falling edge has occurred
    push(8'hA5, 1);
    wait_fall(10, found);
    check("t5_reach_stop", found, 1);
    host_clk_low = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    host_clk_low = 1'b0;
    get_frame("t5_A5", 11'h74A);
    wait_not_busy("t5_idle");
    check("t5_no_abort", abort_cnt, 1);
    check("t5_count_after", fifo_count, 0);

    // 6: asynchronous reset during CLK_LOW of bit index 3
    push(8'h3A, 1);
    wait_fall(3, found);
    check("t6_reach_bit3", found, 1);
    check("t6_clk_oe_before", ps2_clk_oe, 1);
    check("t6_data_oe_before", ps2_data_oe, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_clk_oe", ps2_clk_oe, 0);
    check("t6_data_oe", ps2_data_oe, 0);
    check("t6_count", fifo_count, 0);
    check("t6_ready", tx_ready, 1);
    check("t6_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bit_q.delete();
    repeat (40) @(posedge clk);
    #1;
    check("t6_quiet_after_reset", bit_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
